// File: rtl/frame_source_arbiter.sv
// frame_source_arbiter
//   Shares one 17-bit pixel queue write port between two frame producers.
//   Source 0 is the camera path and source 1 is the debug pattern generator.
//   The grant only moves between frames, so the reader never sees a spliced
//   frame.  Words from the non-granted source are accepted and thrown away,
//   so free-running producers never stall.
//
// Ports
//   clk, reset_n                 clock / async active-low reset
//   src_sel                      requested source (0 camera, 1 pattern)
//   s{0,1}_queue_data/_wr_en     producer write ports (bit16 = control flag)
//   s{0,1}_queue_full            back-pressure, only the granted source sees it
//   queue_data/_wr_en/_wr_clk    registered queue write port
//   queue_full                   queue full flag (must leave 1 spare entry)
//   active_src, in_frame         current grant / frame in progress
//   frame_count                  completed frames forwarded (wraps)
//   drop_count                   discarded words (saturates)

// Per-source qualification: splits one producer's write into the granted
// and non-granted paths and flags control words.
module fsa_src_port #(
  parameter logic [16:0] SOF_WORD = 17'h10000,
  parameter logic [16:0] EOF_WORD = 17'h1FFFF
) (
  input  logic        granted,
  input  logic        wr_en,
  input  logic [16:0] data,
  input  logic        queue_full,
  output logic        full,
  output logic        g_wr,
  output logic        n_wr,
  output logic        g_sof,
  output logic        g_eof,
  output logic [16:0] g_data
);
  assign full   = granted & queue_full;
  assign g_wr   = granted & wr_en;
  assign n_wr   = ~granted & wr_en;
  assign g_sof  = granted & (data == SOF_WORD);
  assign g_eof  = granted & (data == EOF_WORD);
  // zeroed when not granted so the top can OR the sources together
  assign g_data = granted ? data : '0;
endmodule

module frame_source_arbiter #(
  parameter logic [16:0] SOF_WORD  = 17'h10000,
  parameter logic [16:0] EOF_WORD  = 17'h1FFFF,
  parameter int          CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 src_sel,
  input  logic [16:0]          s0_queue_data,
  input  logic                 s0_queue_wr_en,
  output logic                 s0_queue_full,
  input  logic [16:0]          s1_queue_data,
  input  logic                 s1_queue_wr_en,
  output logic                 s1_queue_full,
  output logic [16:0]          queue_data,
  output logic                 queue_wr_en,
  output logic                 queue_wr_clk,
  input  logic                 queue_full,
  output logic                 active_src,
  output logic                 in_frame,
  output logic [CNT_WIDTH-1:0] frame_count,
  output logic [CNT_WIDTH-1:0] drop_count
);
  localparam int NUM_SRC = 2;

  typedef enum logic {WAIT_SOF = 1'b0, IN_FRAME = 1'b1} state_t;

  state_t state_q, state_d;
  logic   grant_d;

  // source ports gathered into packed arrays for the per-source instances
  logic [NUM_SRC-1:0]       src_wr, src_grant, src_full;
  logic [NUM_SRC-1:0]       p_gwr, p_nwr, p_gsof, p_geof;
  logic [NUM_SRC-1:0][16:0] src_data, p_gdata;

  assign src_wr    = {s1_queue_wr_en, s0_queue_wr_en};
  assign src_data  = {s1_queue_data, s0_queue_data};
  assign src_grant = {active_src, ~active_src};

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    fsa_src_port #(.SOF_WORD(SOF_WORD), .EOF_WORD(EOF_WORD)) u_port (
      .granted    (src_grant[s]),
      .wr_en      (src_wr[s]),
      .data       (src_data[s]),
      .queue_full (queue_full),
      .full       (src_full[s]),
      .g_wr       (p_gwr[s]),
      .n_wr       (p_nwr[s]),
      .g_sof      (p_gsof[s]),
      .g_eof      (p_geof[s]),
      .g_data     (p_gdata[s])
    );
  end

  assign s0_queue_full = src_full[0];
  assign s1_queue_full = src_full[1];
  assign queue_wr_clk  = clk;
  assign in_frame      = (state_q == IN_FRAME);

  // granted-source view, decoded against the grant in force this cycle
  logic        gw, nw, gsof, geof;
  logic [16:0] gd;
  assign gw   = |p_gwr;
  assign nw   = |p_nwr;
  assign gsof = |(p_gsof & p_gwr);
  assign geof = |(p_geof & p_gwr);
  assign gd   = p_gdata[0] | p_gdata[1];

  logic fwd, g_drop, frame_done;

  always_comb begin
    state_d    = state_q;
    grant_d    = active_src;
    fwd        = 1'b0;
    g_drop     = 1'b0;
    frame_done = 1'b0;
    unique case (state_q)
      WAIT_SOF: begin
        grant_d = src_sel;
        if (gsof) begin
          // a granted SOF pins the grant even if src_sel moved this cycle
          fwd     = 1'b1;
          grant_d = active_src;
          state_d = IN_FRAME;
        end else if (gw) begin
          g_drop = 1'b1;
        end
      end
      IN_FRAME: begin
        // a repeated SOF is a producer restart: forwarded, no state change
        if (gw) begin
          fwd = 1'b1;
          if (geof) begin
            frame_done = 1'b1;
            state_d    = WAIT_SOF;
          end
        end
      end
      default: state_d = WAIT_SOF;
    endcase
  end

  // saturating drop counter; up to two discards per cycle
  logic [1:0]           drop_inc;
  logic [CNT_WIDTH:0]   drop_sum;
  logic [CNT_WIDTH-1:0] drop_next;
  assign drop_inc  = {1'b0, g_drop} + {1'b0, nw};
  assign drop_sum  = {1'b0, drop_count} + (CNT_WIDTH+1)'(drop_inc);
  assign drop_next = drop_sum[CNT_WIDTH] ? '1 : drop_sum[CNT_WIDTH-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= WAIT_SOF;
      active_src  <= 1'b0;
      queue_data  <= '0;
      queue_wr_en <= 1'b0;
      frame_count <= '0;
      drop_count  <= '0;
    end else begin
      state_q     <= state_d;
      active_src  <= grant_d;
      queue_wr_en <= fwd;
      if (fwd) queue_data <= gd;
      if (frame_done) frame_count <= frame_count + 1'b1;
      drop_count  <= drop_next;
    end
  end
endmodule

// File: tb/tb_frame_source_arbiter.sv
// Bench for frame_source_arbiter: two instances (16-bit and 4-bit counters)
// share the stimulus; a frame-level model predicts every output each cycle,
// and directed sequences pin the model with hand-computed values.
module tb_frame_source_arbiter;
  localparam logic [16:0] SOF = 17'h10000;
  localparam logic [16:0] EOF = 17'h1FFFF;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        src_sel = 1'b0, queue_full = 1'b0;
  logic        s0_wr = 1'b0, s1_wr = 1'b0;
  logic [16:0] s0_d = '0, s1_d = '0;

  logic        a_s0f, a_s1f, a_qwe, a_qclk, a_act, a_inf;
  logic [16:0] a_qd;
  logic [15:0] a_fc, a_dc;
  logic        b_s0f, b_s1f, b_qwe, b_qclk, b_act, b_inf;
  logic [16:0] b_qd;
  logic [3:0]  b_fc, b_dc;

  frame_source_arbiter u_dut (
    .clk(clk), .reset_n(reset_n), .src_sel(src_sel),
    .s0_queue_data(s0_d), .s0_queue_wr_en(s0_wr), .s0_queue_full(a_s0f),
    .s1_queue_data(s1_d), .s1_queue_wr_en(s1_wr), .s1_queue_full(a_s1f),
    .queue_data(a_qd), .queue_wr_en(a_qwe), .queue_wr_clk(a_qclk),
    .queue_full(queue_full), .active_src(a_act), .in_frame(a_inf),
    .frame_count(a_fc), .drop_count(a_dc)
  );

  frame_source_arbiter #(.CNT_WIDTH(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .src_sel(src_sel),
    .s0_queue_data(s0_d), .s0_queue_wr_en(s0_wr), .s0_queue_full(b_s0f),
    .s1_queue_data(s1_d), .s1_queue_wr_en(s1_wr), .s1_queue_full(b_s1f),
    .queue_data(b_qd), .queue_wr_en(b_qwe), .queue_wr_clk(b_qclk),
    .queue_full(queue_full), .active_src(b_act), .in_frame(b_inf),
    .frame_count(b_fc), .drop_count(b_dc)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // grant, whether a frame is open, last queue write, and unbounded totals
  logic        m_g = 1'b0, m_open = 1'b0, m_qwe = 1'b0;
  logic [16:0] m_qd = '0;
  int          m_frames = 0, m_drops = 0;

  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      m_g = 1'b0; m_open = 1'b0; m_qwe = 1'b0; m_qd = '0;
      m_frames = 0; m_drops = 0;
    end else begin
      logic        my_wr, other_wr;
      logic [16:0] my_d;
      my_wr    = m_g ? s1_wr : s0_wr;
      my_d     = m_g ? s1_d  : s0_d;
      other_wr = m_g ? s0_wr : s1_wr;
      m_qwe    = 1'b0;
      if (other_wr) m_drops = m_drops + 1;
      if (my_wr && (m_open || my_d == SOF)) begin
        m_qwe = 1'b1;
        m_qd  = my_d;
        if (m_open && my_d == EOF) begin
          m_open   = 1'b0;
          m_frames = m_frames + 1;
        end else begin
          m_open = 1'b1;
        end
      end else begin
        if (my_wr) m_drops = m_drops + 1;
        if (!m_open) m_g = src_sel;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [16:0] got_q[$];

  initial forever begin
    @(negedge clk);
    if (reset_n) begin
      chk("qwe",    32'(a_qwe), 32'(m_qwe));
      chk("qdata",  32'(a_qd),  32'(m_qd));
      chk("active", 32'(a_act), 32'(m_g));
      chk("inframe",32'(a_inf), 32'(m_open));
      chk("s0full", 32'(a_s0f), 32'(!m_g && queue_full));
      chk("s1full", 32'(a_s1f), 32'(m_g && queue_full));
      chk("fc16",   32'(a_fc),  32'(m_frames % 65536));
      chk("dc16",   32'(a_dc),  (m_drops > 65535) ? 32'hFFFF : 32'(m_drops));
      chk("fc4",    32'(b_fc),  32'(m_frames % 16));
      chk("dc4",    32'(b_dc),  (m_drops > 15) ? 32'hF : 32'(m_drops));
      chk("qwe4",   32'(b_qwe), 32'(m_qwe));
      chk("qclk",   32'(a_qclk), 32'(clk));
      if (a_qwe) got_q.push_back(a_qd);
    end
  end

  // ---------------- stimulus helpers ----------------
  // inputs change 2 time units after a rising edge and are consumed by the next
  task automatic step(input logic sel, input logic w0, input logic [16:0] d0,
                      input logic w1, input logic [16:0] d1);
    @(posedge clk);
    #2;
    src_sel = sel; s0_wr = w0; s0_d = d0; s1_wr = w1; s1_d = d1;
  endtask

  task automatic chk_log(input string nm, input logic [16:0] exp[$]);
    chk({nm, "_len"}, 32'(got_q.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < got_q.size(); i++)
      chk($sformatf("%s_w%0d", nm, i), 32'(got_q[i]), 32'(exp[i]));
    got_q.delete();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    s0_wr = 1'b0; s1_wr = 1'b0; queue_full = 1'b0;
    reset_n = 1'b0;
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    got_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  logic [16:0] e[$];

  initial begin
    // ---- reset state, then one camera frame ----
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    #1;
    chk("rst_qwe", 32'(a_qwe), 32'd0);
    chk("rst_qd",  32'(a_qd),  32'd0);
    chk("rst_act", 32'(a_act), 32'd0);
    chk("rst_inf", 32'(a_inf), 32'd0);
    chk("rst_fc",  32'(a_fc),  32'd0);
    chk("rst_dc",  32'(a_dc),  32'd0);

    step(0, 1, SOF, 0, 0);
    step(0, 1, 17'h00011, 0, 0);
    #1 chk("t1_lat_qwe", 32'(a_qwe), 32'd1);
    chk("t1_lat_qd", 32'(a_qd), 32'(SOF));
    step(0, 1, 17'h00022, 0, 0);
    step(0, 1, 17'h00033, 0, 0);
    step(0, 1, 17'h00044, 0, 0);
    step(0, 1, EOF, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    #1 chk("t1_fc", 32'(a_fc), 32'd1);
    chk("t1_dc", 32'(a_dc), 32'd0);
    step(0, 0, 0, 0, 0);
    e = '{SOF, 17'h00011, 17'h00022, 17'h00033, 17'h00044, EOF};
    chk_log("t1", e);

    // ---- switch request mid camera frame, pattern frames, SOF+sel race ----
    step(0, 1, SOF, 0, 0);
    step(1, 1, 17'h000aa, 0, 0);
    step(1, 1, 17'h000bb, 0, 0);
    step(1, 1, EOF, 0, 0);
    step(1, 0, 0, 1, 17'h00123);
    #1 chk("t2_act_eof", 32'(a_act), 32'd0);
    chk("t2_fc", 32'(a_fc), 32'd2);
    step(1, 0, 0, 1, 17'h00456);
    #1 chk("t2_act_sw", 32'(a_act), 32'd1);
    chk("t2_dc1", 32'(a_dc), 32'd1);
    step(1, 0, 0, 1, SOF);
    step(1, 1, 17'h000cc, 1, 17'h00777);
    step(1, 0, 0, 1, EOF);
    step(0, 0, 0, 1, SOF);
    step(0, 0, 0, 1, EOF);
    #1 chk("t2_race_act", 32'(a_act), 32'd1);
    chk("t2_race_inf", 32'(a_inf), 32'd1);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    #1 chk("t2_act_back", 32'(a_act), 32'd0);
    chk("t2_fc4", 32'(a_fc), 32'd4);
    chk("t2_dc3", 32'(a_dc), 32'd3);
    step(0, 0, 0, 0, 0);
    e = '{SOF, 17'h000aa, 17'h000bb, EOF, SOF, 17'h00777, EOF, SOF, EOF};
    chk_log("t2", e);

    // ---- drops only, counter saturation on a double discard ----
    do_reset();
    repeat (7) step(0, 1, EOF, 1, 17'h00002);
    step(0, 0, 0, 0, 0);
    #1 chk("t3_dc14", 32'(a_dc), 32'd14);
    chk("t3_dc4_14", 32'(b_dc), 32'd14);
    step(0, 1, 17'h00001, 1, 17'h00002);
    step(0, 0, 0, 0, 0);
    #1 chk("t3_dc16", 32'(a_dc), 32'd16);
    chk("t3_dc4_sat", 32'(b_dc), 32'd15);
    repeat (2) step(0, 1, 17'h00001, 1, SOF);
    step(0, 0, 0, 0, 0);
    #1 chk("t3_dc20", 32'(a_dc), 32'd20);
    chk("t3_dc4_sat2", 32'(b_dc), 32'd15);
    step(0, 0, 0, 0, 0);
    e = {};
    chk_log("t3", e);

    // ---- back-pressure while pattern source is granted ----
    do_reset();
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    #1 chk("t4_act", 32'(a_act), 32'd1);
    step(1, 0, 0, 1, SOF);
    step(1, 0, 0, 1, 17'h00101);
    step(1, 0, 0, 0, 0);
    queue_full = 1'b1;
    #1 chk("t4_s1full", 32'(a_s1f), 32'd1);
    chk("t4_s0full", 32'(a_s0f), 32'd0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 17'h00102);
    queue_full = 1'b0;
    step(1, 0, 0, 1, EOF);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    #1 chk("t4_fc", 32'(a_fc), 32'd1);
    e = '{SOF, 17'h00101, 17'h00102, EOF};
    chk_log("t4", e);

    // ---- async reset mid-frame ----
    step(0, 0, 0, 1, SOF);
    step(0, 0, 0, 1, 17'h00202);
    #1 reset_n = 1'b0;
    #1 chk("t5_qwe", 32'(a_qwe), 32'd0);
    chk("t5_qd",  32'(a_qd),  32'd0);
    chk("t5_act", 32'(a_act), 32'd0);
    chk("t5_inf", 32'(a_inf), 32'd0);
    chk("t5_fc",  32'(a_fc),  32'd0);
    chk("t5_dc",  32'(a_dc),  32'd0);
    step(0, 0, 0, 0, 0);
    reset_n = 1'b1;
    got_q.delete();
    step(0, 1, 17'h00301, 0, 0);
    step(0, 1, EOF, 0, 0);
    step(0, 1, SOF, 0, 0);
    step(0, 1, EOF, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    #1 chk("t5_fc1", 32'(a_fc), 32'd1);
    chk("t5_dc2", 32'(a_dc), 32'd2);
    step(0, 0, 0, 0, 0);
    e = '{SOF, EOF};
    chk_log("t5", e);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
